// File: rtl/peb_bus_mux.sv
// Upstream stage of the peripheral expansion box. It splits 16-bit CPU accesses in the
// external window into two 8-bit bus cycles (odd byte, then even byte) and reassembles read data.
module peb_bus_mux #(
   parameter int unsigned WAIT_TICKS = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_clk_en,
   input  logic [0:14] cpu_a,
   input  logic [0:15] cpu_d,
   output logic [0:15] cpu_q,
   input  logic        cpu_memen,
   input  logic        cpu_we,
   input  logic        ext_select,
   output logic        cpu_ready,
   output logic [0:15] a,
   output logic [0:7]  d,
   input  logic [0:7]  q,
   output logic        memen,
   output logic        dbin,
   output logic        we,
   input  logic        ready
);

   typedef enum logic [1:0] {IDLE = 2'd0, ODD = 2'd1, EVEN = 2'd2, DONE = 2'd3} state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_TICKS);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [0:15] a_q, a_d;
   logic [0:7]  d_q, d_d;
   logic [0:15] cpu_q_q, cpu_q_d;
   logic        memen_q, memen_d;
   logic        dbin_q, dbin_d;
   logic        we_q, we_d;
   logic        phase_done_s;

   // A phase ends once the minimum tick count has elapsed and every card reports ready.
   assign phase_done_s = (cnt_q <= 4'd1) && ready;

   // Next-state and next-output computation; nothing moves without a CPU clock-enable tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      a_d     = a_q;
      d_d     = d_q;
      cpu_q_d = cpu_q_q;
      memen_d = memen_q;
      dbin_d  = dbin_q;
      we_d    = we_q;
      if (cpu_clk_en) begin
         case (state_q)
            IDLE: begin
               if (cpu_memen && ext_select) begin
                  state_d = ODD;
                  wr_d    = cpu_we;
                  a_d     = {cpu_a, 1'b1};
                  d_d     = cpu_d[8:15];
                  memen_d = 1'b1;
                  dbin_d  = !cpu_we;
                  we_d    = cpu_we;
                  cnt_d   = WAIT_LD;
               end else begin
                  state_d = IDLE;
               end
            end
            ODD, EVEN: begin
               // An abort wins over a completing phase: the partial byte is discarded.
               if (!cpu_memen) begin
                  state_d = IDLE;
                  memen_d = 1'b0;
                  dbin_d  = 1'b0;
                  we_d    = 1'b0;
               end else if (phase_done_s) begin
                  if (state_q == ODD) begin
                     if (!wr_q) begin
                        cpu_q_d[8:15] = q;
                     end else begin
                        cpu_q_d = cpu_q_q;
                     end
                     state_d = EVEN;
                     a_d     = {cpu_a, 1'b0};
                     d_d     = cpu_d[0:7];
                     cnt_d   = WAIT_LD;
                  end else begin
                     if (!wr_q) begin
                        cpu_q_d[0:7] = q;
                     end else begin
                        cpu_q_d = cpu_q_q;
                     end
                     state_d = DONE;
                     memen_d = 1'b0;
                     dbin_d  = 1'b0;
                     we_d    = 1'b0;
                  end
               end else if (cnt_q != 4'd0) begin
                  cnt_d = cnt_q - 4'd1;
               end else begin
                  cnt_d = cnt_q;
               end
            end
            DONE: begin
               if (!cpu_memen) begin
                  state_d = IDLE;
               end else begin
                  state_d = DONE;
               end
            end
            default: begin
               state_d = IDLE;
               memen_d = 1'b0;
               dbin_d  = 1'b0;
               we_d    = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and registered bus/CPU outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         a_q     <= 16'h0000;
         d_q     <= 8'h00;
         cpu_q_q <= 16'h0000;
         memen_q <= 1'b0;
         dbin_q  <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         a_q     <= a_d;
         d_q     <= d_d;
         cpu_q_q <= cpu_q_d;
         memen_q <= memen_d;
         dbin_q  <= dbin_d;
         we_q    <= we_d;
      end
   end

   assign cpu_ready = ((state_q == IDLE) && !(cpu_memen && ext_select)) || (state_q == DONE);
   assign a     = a_q;
   assign d     = d_q;
   assign cpu_q = cpu_q_q;
   assign memen = memen_q;
   assign dbin  = dbin_q;
   assign we    = we_q;

endmodule

// File: tb/tb_peb_bus_mux.sv
// Directed bench for peb_bus_mux: reads, writes, bus stalls, non-window access, abort and reset.
module tb_peb_bus_mux;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_clk_en;
   logic [0:14] cpu_a;
   logic [0:15] cpu_d;
   logic [0:15] cpu_q;
   logic        cpu_memen;
   logic        cpu_we;
   logic        ext_select;
   logic        cpu_ready;
   logic [0:15] a;
   logic [0:7]  d;
   logic [0:7]  q;
   logic        memen;
   logic        dbin;
   logic        we;
   logic        ready;
   logic [0:7]  q_odd;
   logic [0:7]  q_even;

   int nerr = 0;
   int nchk = 0;
   int n;

   peb_bus_mux #(.WAIT_TICKS(2)) dut (
      .clk(clk), .reset(reset), .cpu_clk_en(cpu_clk_en), .cpu_a(cpu_a), .cpu_d(cpu_d),
      .cpu_q(cpu_q), .cpu_memen(cpu_memen), .cpu_we(cpu_we), .ext_select(ext_select),
      .cpu_ready(cpu_ready), .a(a), .d(d), .q(q), .memen(memen), .dbin(dbin), .we(we),
      .ready(ready)
   );

   always #5 clk = ~clk;

   // Expansion card model: returns the odd or even byte depending on the address LSB.
   assign q = a[15] ? q_odd : q_even;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until cpu_ready rises, bounded; n counts ticks after the request tick.
   task automatic wait_ready(input int start);
      n = start;
      while (!cpu_ready && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      reset = 1'b1; cpu_clk_en = 1'b1; cpu_a = 15'h0000; cpu_d = 16'h0000;
      cpu_memen = 1'b0; cpu_we = 1'b0; ext_select = 1'b0; ready = 1'b1;
      q_odd = 8'h00; q_even = 8'h00;
      #1;
      chk("rst_a", a, 16'h0000);
      chk("rst_strobes", {13'd0, memen, dbin, we}, 16'h0000);
      chk("rst_cpu_q", cpu_q, 16'h0000);
      chk("rst_ready", {15'd0, cpu_ready}, 16'h0001);
      tick();
      reset = 1'b0;
      tick();

      // Read of byte address 0x4000.
      cpu_a = 15'h2000; cpu_we = 1'b0; cpu_memen = 1'b1; ext_select = 1'b1;
      q_odd = 8'h34; q_even = 8'h12;
      #1;
      chk("rd_req_ready", {15'd0, cpu_ready}, 16'h0000);
      tick();
      chk("rd_odd_a", a, 16'h4001);
      chk("rd_odd_strobes", {13'd0, memen, dbin, we}, 16'h0006);
      tick();
      tick();
      chk("rd_even_a", a, 16'h4000);
      chk("rd_even_dbin", {15'd0, dbin}, 16'h0001);
      wait_ready(2);
      chk("rd_latency", 16'(n), 16'd4);
      chk("rd_cpu_q", cpu_q, 16'h1234);
      chk("rd_done_strobes", {13'd0, memen, dbin, we}, 16'h0000);
      chk("rd_done_a", a, 16'h4000);
      cpu_memen = 1'b0;
      tick();

      // Write 0xABCD to byte address 0x6000.
      cpu_a = 15'h3000; cpu_d = 16'hABCD; cpu_we = 1'b1; cpu_memen = 1'b1;
      tick();
      chk("wr_odd_a", a, 16'h6001);
      chk("wr_odd_d", {8'd0, d}, 16'h00CD);
      chk("wr_odd_strobes", {13'd0, memen, dbin, we}, 16'h0005);
      tick();
      tick();
      chk("wr_even_a", a, 16'h6000);
      chk("wr_even_d", {8'd0, d}, 16'h00AB);
      chk("wr_even_strobes", {13'd0, memen, dbin, we}, 16'h0005);
      wait_ready(2);
      chk("wr_latency", 16'(n), 16'd4);
      chk("wr_cpu_q_kept", cpu_q, 16'h1234);
      cpu_memen = 1'b0; cpu_we = 1'b0;
      tick();

      // Read with the bus holding ready low for three extra ticks in the odd phase.
      cpu_a = 15'h2000; cpu_memen = 1'b1; q_odd = 8'h56; q_even = 8'h78;
      tick();
      tick();
      ready = 1'b0;
      tick();
      tick();
      tick();
      chk("stall_a", a, 16'h4001);
      chk("stall_ready", {15'd0, cpu_ready}, 16'h0000);
      ready = 1'b1;
      tick();
      chk("stall_even_a", a, 16'h4000);
      wait_ready(5);
      chk("stall_latency", 16'(n), 16'd7);
      chk("stall_cpu_q", cpu_q, 16'h7856);
      cpu_memen = 1'b0;
      tick();

      // Non-window access passes with no bus activity.
      cpu_a = 15'h1234; cpu_memen = 1'b1; ext_select = 1'b0;
      #1;
      chk("nw_ready", {15'd0, cpu_ready}, 16'h0001);
      tick();
      tick();
      chk("nw_strobes", {13'd0, memen, dbin, we}, 16'h0000);
      chk("nw_a", a, 16'h4000);
      chk("nw_cpu_q", cpu_q, 16'h7856);
      chk("nw_ready2", {15'd0, cpu_ready}, 16'h0001);

      // Without a clock-enable tick a window request must not start.
      ext_select = 1'b1; cpu_clk_en = 1'b0;
      tick();
      tick();
      chk("cen_hold_memen", {15'd0, memen}, 16'h0000);
      chk("cen_hold_a", a, 16'h4000);
      cpu_memen = 1'b0; cpu_clk_en = 1'b1;
      tick();

      // Abort during the even phase.
      cpu_a = 15'h2000; cpu_memen = 1'b1; q_odd = 8'h9A; q_even = 8'hBC;
      tick();
      tick();
      tick();
      chk("ab_even_a", a, 16'h4000);
      chk("ab_odd_byte", cpu_q, 16'h789A);
      cpu_memen = 1'b0;
      tick();
      chk("ab_strobes", {13'd0, memen, dbin, we}, 16'h0000);
      chk("ab_ready", {15'd0, cpu_ready}, 16'h0001);
      tick();
      chk("ab_cpu_q", cpu_q, 16'h789A);

      // Reset pulsed during the odd phase, then a fresh request.
      cpu_memen = 1'b1; q_odd = 8'hDE; q_even = 8'hF0;
      tick();
      tick();
      chk("rs_pre_a", a, 16'h4001);
      reset = 1'b1;
      #1;
      chk("rs_a", a, 16'h0000);
      chk("rs_strobes", {13'd0, memen, dbin, we}, 16'h0000);
      chk("rs_cpu_q", cpu_q, 16'h0000);
      chk("rs_ready", {15'd0, cpu_ready}, 16'h0000);
      tick();
      reset = 1'b0;
      tick();
      chk("rs_new_a", a, 16'h4001);
      wait_ready(0);
      chk("rs_latency", 16'(n), 16'd4);
      chk("rs_cpu_q2", cpu_q, 16'hF0DE);
      cpu_memen = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
